// File: rtl/repeat_iogroup_bank.sv
// Wishbone slave with N_CH repeated groups: R/W control word plus a status word with a sticky W1C event bit.
// Define REPEAT_IOGROUP_BANK_WSTROBE_EN to add ctrl_wr_o, a one-cycle pulse per channel after each CTRL update.
module repeat_iogroup_bank #(
  parameter int unsigned        N_CH     = 4,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  CTRL_RST = '0,
  localparam int unsigned       AW       = (N_CH > 1) ? $clog2(2 * N_CH) : 1,
  localparam int unsigned       NB       = DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [AW-1:0]            wb_adr_i,
  input  logic [NB-1:0]            wb_sel_i,
  input  logic                     wb_we_i,
  input  logic [DATA_W-1:0]        wb_dat_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic                     wb_stall_o,
  output logic [DATA_W-1:0]        wb_dat_o,
  output logic [N_CH*DATA_W-1:0]   ctrl_o,
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
  output logic [N_CH-1:0]          ctrl_wr_o,
`endif
  input  logic [N_CH-1:0]          sts_i,
  input  logic [N_CH-1:0]          evt_i,
  output logic [N_CH-1:0]          evt_o
);

  logic en, rd_req, wr_req, wr_ack;

  logic              rd_busy_q, rd_busy_d;
  logic              rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_mux;

  logic              wr_busy_q, wr_busy_d;
  logic              wr_vld_q, wr_vld_d;
  logic [AW-1:0]     wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0] wr_dat_q, wr_dat_d;
  logic [NB-1:0]     wr_sel_q, wr_sel_d;

  logic [DATA_W-1:0] ctrl_q [N_CH];
  logic [DATA_W-1:0] ctrl_d [N_CH];
  logic [N_CH-1:0]   evt_q, evt_d;

`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
  logic [N_CH-1:0]   ctrl_wr_q, ctrl_wr_d;
`endif

  // A held strobe issues one request; the in-progress flag drops with the ack.
  assign en     = wb_cyc_i & wb_stb_i;
  assign rd_req = en & ~wb_we_i & ~rd_busy_q;
  assign wr_req = en & wb_we_i & ~wr_busy_q;
  assign wr_ack = wr_vld_q;

  // Read decode in the request cycle; unmapped words fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (wb_adr_i == AW'(2 * c))     rd_mux = ctrl_q[c];
      if (wb_adr_i == AW'(2 * c + 1)) rd_mux = DATA_W'({evt_q[c], sts_i[c]});
    end
  end

  always_comb begin
    rd_busy_d = rd_req | (rd_busy_q & ~rd_ack_q);
    rd_ack_d  = rd_req;
    rdata_d   = rd_req ? rd_mux : rdata_q;
    wr_busy_d = wr_req | (wr_busy_q & ~wr_ack);
    wr_vld_d  = wr_req;
    wr_adr_d  = wr_req ? wb_adr_i : wr_adr_q;
    wr_dat_d  = wr_req ? wb_dat_i : wr_dat_q;
    wr_sel_d  = wr_req ? wb_sel_i : wr_sel_q;
  end

  // Register update lands on the edge that closes the write ack cycle; event set beats W1C clear.
  always_comb begin
    ctrl_d = ctrl_q;
    evt_d  = evt_q;
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
    ctrl_wr_d = '0;
`endif
    if (wr_vld_q) begin
      for (int c = 0; c < N_CH; c++) begin
        if (wr_adr_q == AW'(2 * c)) begin
          for (int k = 0; k < NB; k++) begin
            if (wr_sel_q[k]) ctrl_d[c][8*k +: 8] = wr_dat_q[8*k +: 8];
          end
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
          ctrl_wr_d[c] = |wr_sel_q;
`endif
        end
        if (wr_adr_q == AW'(2 * c + 1) && wr_sel_q[0] && wr_dat_q[1]) evt_d[c] = 1'b0;
      end
    end
    evt_d = evt_d | evt_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_busy_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rdata_q   <= '0;
      wr_busy_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      wr_sel_q  <= '0;
      evt_q     <= '0;
      for (int c = 0; c < N_CH; c++) ctrl_q[c] <= CTRL_RST;
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
      ctrl_wr_q <= '0;
`endif
    end else begin
      rd_busy_q <= rd_busy_d;
      rd_ack_q  <= rd_ack_d;
      rdata_q   <= rdata_d;
      wr_busy_q <= wr_busy_d;
      wr_vld_q  <= wr_vld_d;
      wr_adr_q  <= wr_adr_d;
      wr_dat_q  <= wr_dat_d;
      wr_sel_q  <= wr_sel_d;
      evt_q     <= evt_d;
      for (int c = 0; c < N_CH; c++) ctrl_q[c] <= ctrl_d[c];
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
      ctrl_wr_q <= ctrl_wr_d;
`endif
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ctrl
    assign ctrl_o[c*DATA_W +: DATA_W] = ctrl_q[c];
  end

  assign evt_o      = evt_q;
  assign wb_dat_o   = rdata_q;
  assign wb_ack_o   = rd_ack_q | wr_ack;
  assign wb_stall_o = en & ~wb_ack_o;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
  assign ctrl_wr_o  = ctrl_wr_q;
`endif

endmodule

// File: tb/tb_repeat_iogroup_bank.sv
// Directed bench for repeat_iogroup_bank (N_CH=3, DATA_W=32) against a word-level register model.
module tb_repeat_iogroup_bank;
  localparam int unsigned N_CH = 3;
  localparam int unsigned AW   = 3;
  localparam logic [31:0] RST_V = 32'hA5A5_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0]     wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o;
  logic [31:0]       wb_dat_o;
  logic [N_CH*32-1:0] ctrl_o;
  logic [N_CH-1:0]   sts_i, evt_i, evt_o;
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
  logic [N_CH-1:0]   ctrl_wr_o;
`endif

  repeat_iogroup_bank #(.N_CH(N_CH), .DATA_W(32), .CTRL_RST(RST_V)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o), .wb_stall_o(wb_stall_o), .wb_dat_o(wb_dat_o), .ctrl_o(ctrl_o),
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
    .ctrl_wr_o(ctrl_wr_o),
`endif
    .sts_i(sts_i), .evt_i(evt_i), .evt_o(evt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Register model: word map, byte merge, W1C with set-wins, one-cycle write strobe.
  logic [31:0]     m_ctrl [N_CH];
  logic [N_CH-1:0] m_evt, m_wr;
  bit              pend = 1'b0;
  logic [AW-1:0]   p_adr;
  logic [31:0]     p_dat;
  logic [3:0]      p_sel;
  int              mw;
  bit              chk_en = 1'b0;
  logic [31:0]     rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) m_ctrl[c] = RST_V;
      m_evt = '0;
      m_wr  = '0;
      pend  = 1'b0;
    end else begin
      m_wr = '0;
      if (pend) begin
        mw = int'(p_adr);
        if (mw < 2 * N_CH) begin
          if (mw % 2 == 0) begin
            for (int k = 0; k < 4; k++) if (p_sel[k]) m_ctrl[mw/2][8*k +: 8] = p_dat[8*k +: 8];
            m_wr[mw/2] = |p_sel;
          end else if (p_sel[0] && p_dat[1]) begin
            m_evt[mw/2] = 1'b0;
          end
        end
        pend = 1'b0;
      end
      m_evt = m_evt | evt_i;
    end
  end

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int w = int'(a);
    if (w >= 2 * N_CH) return 32'h0;
    if (w % 2 == 0) return m_ctrl[w/2];
    return {30'b0, m_evt[w/2], sts_i[w/2]};
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int c = 0; c < N_CH; c++) check($sformatf("ctrl%0d", c), ctrl_o[c*32 +: 32], m_ctrl[c]);
      check("evt_o", evt_o, m_evt);
      check("err_rty", {wb_err_o, wb_rty_o}, 2'b00);
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
      check("ctrl_wr_o", ctrl_wr_o, m_wr);
`endif
    end
  end

  // One transaction; strobe dropped as soon as the ack is seen. pulse drives evt_i in the update edge.
  task automatic bus(input bit we, input logic [7:0] badr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [N_CH-1:0] pulse, output logic [31:0] rdv);
    logic [31:0] exp;
    int n;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = badr[AW+1:2]; wb_dat_i = dat; wb_sel_i = sel;
    exp = model_read(badr[AW+1:2]);
    #1 check("stall_req", wb_stall_o, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 8);
    check("ack_latency", n, 1);
    check("stall_ack", wb_stall_o, 1'b0);
    if (!we) check("rdata", wb_dat_o, exp);
    rdv = wb_dat_o;
    if (we && wb_ack_o) begin
      pend = 1'b1; p_adr = badr[AW+1:2]; p_dat = dat; p_sel = sel;
    end
    evt_i = pulse;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    evt_i = '0;
    check("single_ack", wb_ack_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    sts_i = '0; evt_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl_o, {3{RST_V}});
    check("rst_evt", evt_o, 3'b000);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    bus(1'b0, 8'h08, 32'h0, 4'hF, '0, rd);
    check("rd_ctrl1_rst", rd, 32'hA5A5_0000);

    bus(1'b1, 8'h08, 32'h1122_3344, 4'b0101, '0, rd);
    check("bytesel_ctrl", ctrl_o, {32'hA5A5_0000, 32'hA522_0044, 32'hA5A5_0000});

    @(negedge clk); sts_i[2] = 1'b1; evt_i[2] = 1'b1;
    @(negedge clk); evt_i = '0;
    bus(1'b0, 8'h14, 32'h0, 4'hF, '0, rd);
    check("sts2_live_evt", rd, 32'h0000_0003);
    sts_i[2] = 1'b0;
    bus(1'b0, 8'h14, 32'h0, 4'hF, '0, rd);
    check("sts2_evt_only", rd, 32'h0000_0002);

    bus(1'b1, 8'h14, 32'h2, 4'h1, 3'b100, rd);
    check("w1c_collision", evt_o[2], 1'b1);
    bus(1'b1, 8'h14, 32'h2, 4'h1, '0, rd);
    check("w1c_clear", evt_o[2], 1'b0);

    bus(1'b0, 8'h18, 32'h0, 4'hF, '0, rd);
    check("unmapped_rd", rd, 32'h0);
    bus(1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF, '0, rd);
    check("unmapped_wr", ctrl_o, {32'hA5A5_0000, 32'hA522_0044, 32'hA5A5_0000});
    check("unmapped_evt", evt_o, 3'b000);

    bus(1'b1, 8'h10, 32'hDEAD_BEEF, 4'b1010, '0, rd);
    bus(1'b0, 8'h10, 32'h0, 4'hF, '0, rd);
    check("ctrl2_merge", rd, 32'hDEA5_BE00);

    bus(1'b1, 8'h00, 32'h1, 4'hF, '0, rd);
    check("ctrl0_full", ctrl_o[31:0], 32'h1);
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
    check("wstrobe_pulse", ctrl_wr_o, 3'b001);
    @(negedge clk);
    check("wstrobe_single", ctrl_wr_o, 3'b000);
`endif
    bus(1'b1, 8'h00, 32'hFFFF_FFFF, 4'h0, '0, rd);
    check("sel0_nochange", ctrl_o[31:0], 32'h1);
`ifdef REPEAT_IOGROUP_BANK_WSTROBE_EN
    check("wstrobe_sel0", ctrl_wr_o, 3'b000);
`endif

    bus(1'b0, 8'h04, 32'h0, 4'hF, '0, rd);
    check("sts0_idle", rd, 32'h0);
    @(negedge clk); evt_i[1] = 1'b1;
    @(negedge clk); evt_i = '0;
    bus(1'b0, 8'h0C, 32'h0, 4'hF, '0, rd);
    check("sts1_evt", rd, 32'h0000_0002);

    // Asynchronous reset in the middle of a write ack cycle drops the transaction.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd4; wb_dat_i = 32'h55; wb_sel_i = 4'hF;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ack", wb_ack_o, 1'b0);
    check("arst_ctrl", ctrl_o, {3{RST_V}});
    check("arst_evt", evt_o, 3'b000);
    check("arst_dat", wb_dat_o, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 8'h10, 32'h0, 4'hF, '0, rd);
    check("post_rst_ctrl2", rd, 32'hA5A5_0000);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repeat_iogroup_bank.md
Name: repeat_iogroup_bank

Overview:
- Wishbone (classic, stall-signalled) slave exposing N_CH repeated I/O groups.
- Each group has:
  - a read/write control register driven out to the fabric;
  - a read-only status word with one live status bit and one sticky, write-1-to-clear event bit.
- Parametrised successor of the single-instance repeat-iogroup register block. Adds channel count, data width, byte-select writes and event latching.
- Sits between the host Wishbone interconnect and per-channel datapath logic.

Parameters:
- N_CH, 4, number of repeated channels (1..64).
- DATA_W, 32, Wishbone data width and control register width (8, 16 or 32).
- CTRL_RST, 0, reset value of every control register (DATA_W bits).
- AW, clog2(2*N_CH) (minimum 1), word-address bits decoded; derived, not to be overridden.

Ports:
- clk_i  in  1  system clock, all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_adr_i  in  AW (bits [AW+1:2])  word address.
- wb_sel_i  in  DATA_W/8  byte selects.
- wb_we_i  in  1  write enable.
- wb_dat_i  in  DATA_W  write data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.
- wb_stall_o  out  1  stall.
- wb_dat_o  out  DATA_W  read data, registered.
- ctrl_o  out  N_CH*DATA_W  control registers; channel c occupies [c*DATA_W +: DATA_W].
- sts_i  in  N_CH  live status, one bit per channel, synchronous to clk_i.
- evt_i  in  N_CH  single-cycle event pulses, one bit per channel.
- evt_o  out  N_CH  sticky event flags, also readable.

Behaviour:
- Reset: rst_i is asynchronous and active-high; it is the only reset in the block. While rst_i is asserted:
  - ctrl_o = CTRL_RST for all channels;
  - evt_o = 0, wb_ack_o = 0, wb_dat_o = 0;
  - read/write in-progress flags and the write pipeline are cleared.
- Reset mid-transaction drops the transaction with no ack. The master must retry.
- Address map, word index w = wb_adr_i:
  - w = 2c: CTRL of channel c.
  - w = 2c+1: STATUS of channel c.
  - w >= 2*N_CH: unmapped.
- STATUS word layout: bit0 = sts_i[c] (live), bit1 = evt_o[c], other bits read 0.
- Request detection:
  - en = cyc & stb.
  - A read request is en & ~we & ~read-in-progress; a write request is en & we & ~write-in-progress.
  - Each in-progress flag sets on request and clears on ack, so a held strobe produces exactly one request.
- Reads:
  - Address is decoded combinationally in the request cycle.
  - wb_dat_o and ack are registered: ack appears exactly 1 cycle after the request cycle.
  - Unmapped reads return 0 and are acked.
- Writes:
  - Address, data and sel are registered (stage d0).
  - ack is combinational from the d0 stage: it appears 1 cycle after the request cycle.
  - The register update occurs on the same edge that ends the ack cycle.
- CTRL write: byte k is updated only if wb_sel_i[k] = 1. sel = 0 still acks but changes nothing.
- STATUS write: if sel[0] = 1, every data bit1 = 1 clears evt_o[c]. Other bits are ignored.
- Unmapped writes are acked and have no effect.
- Event latch: evt_i[c] = 1 sets evt_o[c] on the next edge.
- Simultaneous event and W1C clear on the same edge: set wins, flag stays 1.
- wb_ack_o = rd_ack | wr_ack.
- wb_stall_o = en & ~wb_ack_o.
- wb_err_o = wb_rty_o = 0.
- Back-to-back accesses: one transaction completes every 2 cycles with strobe held. No request overlap is required.

Optional Feature:
- Macro: REPEAT_IOGROUP_BANK_WSTROBE_EN.
- Defined:
  - Adds output port ctrl_wr_o, N_CH bits.
  - ctrl_wr_o[c] pulses high for exactly one cycle, the cycle after CTRL of channel c is updated, aligned with the new ctrl_o value.
  - It pulses on any acked CTRL write with at least one sel bit set.
  - Reset value 0.
- Undefined: the port does not exist. Behaviour is otherwise identical.

Test Plan:
- Reset value: N_CH=3, DATA_W=32, CTRL_RST=0xA5A5_0000. Assert rst_i asynchronously, mid-cycle -> ctrl_o all channels = 0xA5A5_0000, evt_o = 0, wb_ack_o = 0 immediately. Then read adr 0x8 -> 0xA5A5_0000, ack 1 cycle after request.
- Byte-select write: write 0x1122_3344 to adr 0x8 with sel = 4'b0101 -> ctrl_o ch1 = 0xA522_0044. ch0 and ch2 unchanged. Exactly one ack per held strobe.
- Status read and event latching:
  - sts_i[2] = 1 and a one-cycle pulse on evt_i[2], then read adr 0x14 -> 0x0000_0003.
  - Deassert sts_i[2] and re-read -> 0x0000_0002.
- W1C collision: write 0x2 to adr 0x14, with evt_i[2] pulsed on the update edge -> evt_o[2] stays 1. Repeat the write without the pulse -> evt_o[2] = 0.
- Unmapped address: read adr 0x18 -> data 0, ack after 1 cycle. Write 0xFFFF_FFFF to 0x18 -> ack, no ctrl_o or evt_o change. wb_err_o stays 0.
- Write strobe, with REPEAT_IOGROUP_BANK_WSTROBE_EN defined:
  - Write 0x1 to adr 0x0 with sel = 4'hF -> ctrl_wr_o = 3'b001 for one cycle, coincident with ctrl_o ch0 = 0x1.
  - Same write with sel = 0 -> no pulse.
